// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store slave modelling an SRAM with WAIT_CYCLES wait states.
// Optional feature macro DMEM_MISALIGN_TRAP_EN: misaligned or illegal-size accesses return rsp_err_o.
module data_mem_responder #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        mem_busy_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  state_dbg_o
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        q_we;
    logic [2:0]  q_funct3;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o;
    // the response is the single cycle with rsp_valid_o high, with no back-pressure.
    assign req_ready_o = (state_q == S_IDLE);
    assign mem_busy_o  = (state_q == S_WAIT) || (state_q == S_ACCESS);
    assign rsp_valid_o = (state_q == S_RESP);
    assign state_dbg_o = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_we     <= 1'b0;
            q_funct3 <= 3'd0;
            q_addr   <= 32'd0;
            q_wdata  <= 32'd0;
        end else if (req_valid_i && req_ready_o) begin
            q_we     <= req_we_i;
            q_funct3 <= req_funct3_i;
            q_addr   <= req_addr_i;
            q_wdata  <= req_wdata_i;
        end
    end

    logic [1:0]  size;
    logic        illegal;
    logic        err;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] lane_wdata;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic [31:0] load_data;

    assign size    = q_funct3[1:0];
    assign illegal = (size == 2'b11);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err = illegal || (size == 2'b01 && q_addr[0]) || (size == 2'b10 && q_addr[1:0] != 2'b00);
    assign off = q_addr[1:0];
`else
    assign err = 1'b0;
    // Halves and words are silently aligned down instead of trapping.
    always_comb begin
        off = q_addr[1:0];
        if (size == 2'b01) off = {q_addr[1], 1'b0};
        if (size == 2'b10) off = 2'b00;
    end
`endif

    always_comb begin
        be         = 4'b0000;
        lane_wdata = q_wdata;
        case (size)
            2'b00: begin
                be         = 4'b0001 << off;
                lane_wdata = {4{q_wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << {off[1], 1'b0};
                lane_wdata = {2{q_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (err) be = 4'b0000;
    end

    assign idx       = q_addr[2 +: AW];
    assign rd_word   = mem[idx];
    assign load_data = rd_word >> {off, 3'b000};

    // No reset here: a reset before the ACCESS edge leaves state_q out of S_ACCESS, dropping the store.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && q_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
        end else if (state_q == S_ACCESS) begin
            rsp_rdata_o <= (q_we || illegal || err) ? 32'd0 : load_data;
            rsp_err_o   <= err;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, q_funct3[2], q_addr[31:2+AW]};

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed plus randomized checks of data_mem_responder against a byte-array model.
// Two instances: WAIT_CYCLES=2 for the main sequence, WAIT_CYCLES=0 for the back-to-back burst.
module tb_data_mem_responder;
    localparam int WAIT_MAIN = 2;

    logic        clk;
    logic        reset_n;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_busy, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  state_dbg;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_mem_busy, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic [1:0]  b_state_dbg;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  ref_mem [4096];
    logic [31:0] hold_rd;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT_MAIN)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_busy_o(mem_busy), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .state_dbg_o(state_dbg)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_funct3_i(b_req_funct3), .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .mem_busy_o(b_mem_busy), .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
        .rsp_err_o(b_rsp_err), .state_dbg_o(b_state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed store, addresses wrap at 4 KiB.
    task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [11:0] a;
        logic [1:0]  sz;
        logic [31:0] word;
        int          n;
        a  = addr[11:0];
        sz = f3[1:0];
        rd = 32'd0;
        er = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) begin
            er = 1'b1;
            return;
        end
`else
        if (sz == 2'd3) return;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
`endif
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (we) begin
            for (int b = 0; b < n; b++) ref_mem[int'(a) + b] = wd[8*b +: 8];
        end else begin
            word = {ref_mem[{a[11:2], 2'd3}], ref_mem[{a[11:2], 2'd2}],
                    ref_mem[{a[11:2], 2'd1}], ref_mem[{a[11:2], 2'd0}]};
            rd = word >> (8 * a[1:0]);
        end
    endtask

    // Driver: one request on the main instance, returns response and timing observations.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int busy_n);
        @(negedge clk);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        chk("rdata_hold", rsp_rdata, hold_rd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        busy_n = 0;
        while (!rsp_valid && lat < 40) begin
            if (mem_busy) busy_n++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = rsp_rdata;
        er = rsp_err;
        chk("busy_low_in_resp", {31'd0, mem_busy}, 32'd0);
        chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
        hold_rd = rsp_rdata;
    endtask

    // Scoreboard step: model prediction vs DUT response, latency and busy width.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_er, er;
        int          lat, busy_n;
        model_op(we, f3, addr, wd, exp_rd, exp_er);
        issue(we, f3, addr, wd, rd, er, lat, busy_n);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
        chk({tag, "_latency"}, lat, WAIT_MAIN + 1);
        chk({tag, "_busy_cycles"}, busy_n, WAIT_MAIN + 1);
    endtask

    // Back-to-back word burst on the zero-wait instance with req_valid held high.
    task automatic b_burst(input logic we, input logic [31:0] base,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] dd [3];
        int          pulses;
        int          ready_low;
        dd = '{d0, d1, d2};
        pulses = 0;
        ready_low = 0;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = we; b_req_funct3 = 3'b010;
        for (int i = 0; i < 3; i++) begin
            chk("b_ready_idle", {31'd0, b_req_ready}, 32'd1);
            b_req_we = we; b_req_addr = base + 32'(4 * i); b_req_wdata = dd[i];
            @(posedge clk);
            @(negedge clk);
            if (!b_req_ready) ready_low++;
            chk("b_no_rsp_in_access", {31'd0, b_rsp_valid}, 32'd0);
            b_req_we = 1'($urandom); b_req_addr = $urandom; b_req_wdata = $urandom;
            if (i == 2) b_req_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (!b_req_ready) ready_low++;
            if (b_rsp_valid) pulses++;
            chk("b_rdata", b_rsp_rdata, we ? 32'd0 : dd[i]);
            @(posedge clk);
            @(negedge clk);
            chk("b_rsp_one_cycle", {31'd0, b_rsp_valid}, 32'd0);
        end
        chk("b_pulses", pulses, 3);
        chk("b_ready_low_cycles", ready_low, 6);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [2:0]  f3;
        reset_n = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'd0; b_req_addr = 32'd0; b_req_wdata = 32'd0;
        hold_rd = 32'd0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, mem_busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill the low 256 bytes so every later load reads defined data.
        for (int i = 0; i < 64; i++) txn(1'b1, 3'b010, 32'(4 * i), $urandom, "init", rd);

        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "t1_sw", rd);
        txn(1'b0, 3'b010, 32'h10, 32'h0, "t1_lw", rd);
        chk("t1_value", rd, 32'hDEADBEEF);

        txn(1'b1, 3'b010, 32'h20, 32'h11223344, "t2_sw", rd);
        txn(1'b1, 3'b000, 32'h22, 32'h000000AA, "t2_sb", rd);
        txn(1'b0, 3'b010, 32'h20, 32'h0, "t2_lw", rd);
        chk("t2_lw_value", rd, 32'h11AA3344);
        txn(1'b0, 3'b000, 32'h23, 32'h0, "t2_lb", rd);
        chk("t2_lb_value", rd, 32'h00000011);
        txn(1'b0, 3'b100, 32'h21, 32'h0, "t2_lbu", rd);

        txn(1'b1, 3'b001, 32'h32, 32'h1234BEEF, "t3_sh", rd);
        txn(1'b0, 3'b001, 32'h32, 32'h0, "t3_lh", rd);
        chk("t3_lh_low", {16'd0, rd[15:0]}, 32'h0000BEEF);
        txn(1'b0, 3'b001, 32'h31, 32'h0, "t3_lh_mis", rd);
        txn(1'b1, 3'b011, 32'h50, 32'hFFFFFFFF, "illegal_st", rd);
        txn(1'b0, 3'b010, 32'h50, 32'h0, "illegal_chk", rd);
        txn(1'b1, 3'b010, 32'h57, 32'hCAFEF00D, "sw_mis", rd);
        txn(1'b0, 3'b010, 32'h54, 32'h0, "sw_mis_chk", rd);

        txn(1'b1, 3'b010, 32'h1000, 32'h5A5A5A5A, "t4_sw", rd);
        txn(1'b0, 3'b010, 32'h0000, 32'h0, "t4_lw", rd);
        chk("t4_wrap", rd, 32'h5A5A5A5A);

        // Reset during WAIT of a store drops it.
        txn(1'b1, 3'b010, 32'h40, 32'h0, "t5_clear", rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5_busy_before", {31'd0, mem_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, mem_busy}, 32'd0);
        chk("t5_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("t5_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t5_rst_rdata", rsp_rdata, 32'd0);
        chk("t5_rst_err", {31'd0, rsp_err}, 32'd0);
        #2 reset_n = 1'b1;
        hold_rd = 32'd0;
        txn(1'b0, 3'b010, 32'h40, 32'h0, "t5_lw", rd);
        chk("t5_value", rd, 32'h0);

        b_burst(1'b1, 32'h80, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4);
        b_burst(1'b0, 32'h80, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4);

        for (int i = 0; i < 48; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            txn(1'($urandom_range(0, 1)), f3, a, $urandom, "rand", rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
